// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline sizing constants and thread index type
//
// Contents:
//   NUM_THREADS       hardware thread count
//   THREAD_INDEX_BITS width of a thread index (clog2 of NUM_THREADS)
//   REG_INDEX_BITS    architectural register index width
//   DATA_WIDTH        datapath width
//   thread_idx_t      thread index type
package pipeline_pkg;

    localparam int NUM_THREADS       = 8;
    localparam int THREAD_INDEX_BITS = 3;
    localparam int REG_INDEX_BITS    = 5;
    localparam int DATA_WIDTH        = 32;

    typedef logic [THREAD_INDEX_BITS-1:0] thread_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority picker
//
// Ports:
//   req         in   N         request mask, bit i = requester i
//   ptr         in   IDX_BITS  last granted index; search starts just after it
//   grant_valid out  1         at least one request is set
//   grant_index out  IDX_BITS  first requester strictly after ptr, cyclically
module rr_arbiter #(
    parameter int N        = 8,
    parameter int IDX_BITS = 3
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic                grant_valid,
    output logic [IDX_BITS-1:0] grant_index
);

    // Walk from the farthest offset (ptr itself, lowest priority) toward
    // ptr+1 so the last hit written is the highest-priority requester.
    always_comb begin
        grant_valid = 1'b0;
        grant_index = '0;
        for (int k = N; k >= 1; k--) begin
            int pos;
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req[pos[IDX_BITS-1:0]]) begin
                grant_valid = 1'b1;
                grant_index = pos[IDX_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/thread_issue_scheduler.sv
// rtl/thread_issue_scheduler.sv - round-robin thread issue scheduler with pending-op tracking
//
// Optional feature macro: THREAD_SCHED_PERF_EN (bubble counter; tied to 0 when undefined)
//
// Ports:
//   clk               in   1                  clock, rising edge
//   rst               in   1                  async active-high reset
//   thread_enable     in   NUM_THREADS        per-thread enable mask
//   stall             in   1                  hold issue outputs and rr pointer
//   block_valid       in   1                  decode issued a long-latency op
//   block_thread      in   THREAD_INDEX_BITS  owner of that op
//   wb_flag           in   1                  mem2 write-back present
//   wb_thread         in   THREAD_INDEX_BITS  owner of the write-back
//   issue_valid       out  1                  registered: a thread was selected
//   issue_thread      out  THREAD_INDEX_BITS  registered: selected thread
//   eligible_mask     out  NUM_THREADS        combinational eligibility from state
//   err_overflow      out  1                  sticky: block on a saturated thread
//   err_underflow     out  1                  sticky: write-back with zero pending
//   perf_bubble_count out  32                 unstalled cycles with no eligible thread
module thread_issue_scheduler #(
    parameter int NUM_THREADS       = pipeline_pkg::NUM_THREADS,
    parameter int THREAD_INDEX_BITS = pipeline_pkg::THREAD_INDEX_BITS,
    parameter int MAX_PENDING       = 2,
    parameter int PEND_BITS         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_THREADS-1:0]       thread_enable,
    input  logic                         stall,
    input  logic                         block_valid,
    input  logic [THREAD_INDEX_BITS-1:0] block_thread,
    input  logic                         wb_flag,
    input  logic [THREAD_INDEX_BITS-1:0] wb_thread,
    output logic                         issue_valid,
    output logic [THREAD_INDEX_BITS-1:0] issue_thread,
    output logic [NUM_THREADS-1:0]       eligible_mask,
    output logic                         err_overflow,
    output logic                         err_underflow,
    output logic [31:0]                  perf_bubble_count
);

    localparam logic [PEND_BITS-1:0] LP_MAX = PEND_BITS'(MAX_PENDING);

    logic [PEND_BITS-1:0]         r_pending [NUM_THREADS];
    logic [THREAD_INDEX_BITS-1:0] r_rr_ptr;
    logic [NUM_THREADS-1:0]       w_eligible;
    logic [NUM_THREADS-1:0]       w_inc;
    logic [NUM_THREADS-1:0]       w_dec;
    logic                         w_ovf;
    logic                         w_unf;
    logic                         w_grant_valid;
    logic [THREAD_INDEX_BITS-1:0] w_grant_index;

    // An index >= NUM_THREADS never matches any i, so it is silently dropped.
    always_comb begin
        w_eligible = '0;
        w_inc      = '0;
        w_dec      = '0;
        w_ovf      = 1'b0;
        w_unf      = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_eligible[i] = thread_enable[i] && (r_pending[i] < LP_MAX);
            if (block_valid && (block_thread == THREAD_INDEX_BITS'(i))) begin
                if (r_pending[i] < LP_MAX) begin
                    w_inc[i] = 1'b1;
                end else begin
                    w_ovf = 1'b1;
                end
            end
            if (wb_flag && (wb_thread == THREAD_INDEX_BITS'(i))) begin
                if (r_pending[i] != '0) begin
                    w_dec[i] = 1'b1;
                end else begin
                    w_unf = 1'b1;
                end
            end
        end
    end

    assign eligible_mask = w_eligible;

    rr_arbiter #(
        .N        (NUM_THREADS),
        .IDX_BITS (THREAD_INDEX_BITS)
    ) u_rr_arbiter (
        .req         (w_eligible),
        .ptr         (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant_index (w_grant_index)
    );

    // Counters and error flags keep updating under stall; only the issue
    // outputs and the pointer freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid   <= 1'b0;
            issue_thread  <= '0;
            r_rr_ptr      <= THREAD_INDEX_BITS'(NUM_THREADS - 1);
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_pending[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_pending[i] <= r_pending[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_pending[i] <= r_pending[i] - 1'b1;
                end
            end
            if (w_ovf) begin
                err_overflow <= 1'b1;
            end
            if (w_unf) begin
                err_underflow <= 1'b1;
            end
            if (!stall) begin
                if (w_grant_valid) begin
                    issue_valid  <= 1'b1;
                    issue_thread <= w_grant_index;
                    r_rr_ptr     <= w_grant_index;
                end else begin
                    issue_valid  <= 1'b0;
                end
            end
        end
    end

`ifdef THREAD_SCHED_PERF_EN
    logic [31:0] r_bubble_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_count <= 32'd0;
        end else if (!stall && !(|w_eligible) && (r_bubble_count != 32'hFFFF_FFFF)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign perf_bubble_count = r_bubble_count;
`else
    assign perf_bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// tb/tb_thread_issue_scheduler.sv - directed self-checking bench for thread_issue_scheduler
module tb_thread_issue_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] thread_enable;
    logic       stall;
    logic       block_valid;
    logic [2:0] block_thread;
    logic       wb_flag;
    logic [2:0] wb_thread;
    logic       issue_valid;
    logic [2:0] issue_thread;
    logic [7:0] eligible_mask;
    logic       err_overflow;
    logic       err_underflow;
    logic [31:0] perf_bubble_count;

    int n_tests;
    int n_fail;

    thread_issue_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .thread_enable     (thread_enable),
        .stall             (stall),
        .block_valid       (block_valid),
        .block_thread      (block_thread),
        .wb_flag           (wb_flag),
        .wb_thread         (wb_thread),
        .issue_valid       (issue_valid),
        .issue_thread      (issue_thread),
        .eligible_mask     (eligible_mask),
        .err_overflow      (err_overflow),
        .err_underflow     (err_underflow),
        .perf_bubble_count (perf_bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] en);
        block_valid   = 1'b0;
        wb_flag       = 1'b0;
        stall         = 1'b0;
        block_thread  = 3'd0;
        wb_thread     = 3'd0;
        thread_enable = en;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(8'hFF);
        rst = 1'b1;
        #1;
        n_tests++;
        if (issue_valid !== 1'b0 || issue_thread !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_issue: valid=%b thread=%0d required valid=0 thread=0", issue_valid, issue_thread);
        end
        n_tests++;
        if (eligible_mask !== 8'hFF || err_overflow !== 1'b0 || err_underflow !== 1'b0 || perf_bubble_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: elig=%h ovf=%b unf=%b perf=%0d required elig=ff ovf=0 unf=0 perf=0",
                     eligible_mask, err_overflow, err_underflow, perf_bubble_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        do_reset(8'hFF);
        for (int k = 0; k < 9; k++) begin
            tick();
            n_tests++;
            if (issue_valid !== 1'b1 || issue_thread !== 3'(k % 8)) begin
                n_fail++;
                $display("FAIL rotation[%0d]: valid=%b thread=%0d required valid=1 thread=%0d", k, issue_valid, issue_thread, k % 8);
            end
        end
    endtask

    task automatic test_mask();
        logic [2:0] seq [6];
        seq[0] = 3'd0; seq[1] = 3'd2; seq[2] = 3'd5;
        seq[3] = 3'd0; seq[4] = 3'd2; seq[5] = 3'd5;
        do_reset(8'h25);
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++;
            if (issue_valid !== 1'b1 || issue_thread !== seq[k]) begin
                n_fail++;
                $display("FAIL mask_25[%0d]: valid=%b thread=%0d required valid=1 thread=%0d", k, issue_valid, issue_thread, seq[k]);
            end
        end
        thread_enable = 8'h04;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (issue_valid !== 1'b1 || issue_thread !== 3'd2) begin
                n_fail++;
                $display("FAIL mask_04[%0d]: valid=%b thread=%0d required valid=1 thread=2", k, issue_valid, issue_thread);
            end
        end
    endtask

    task automatic test_saturation();
        bit seen3;
        bit found;
        do_reset(8'hFF);
        block_valid  = 1'b1;
        block_thread = 3'd3;
        tick();
        tick();
        block_valid  = 1'b0;
        n_tests++;
        if (eligible_mask !== 8'hF7) begin
            n_fail++;
            $display("FAIL sat_mask: elig=%h required f7", eligible_mask);
        end
        // issues so far 0,1; next is 2, then 3 must be skipped
        tick();
        tick();
        n_tests++;
        if (issue_thread !== 3'd4) begin
            n_fail++;
            $display("FAIL sat_skip: thread=%0d required 4", issue_thread);
        end
        seen3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (issue_valid && issue_thread == 3'd3) seen3 = 1'b1;
        end
        n_tests++;
        if (seen3 !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_never3: seen=%b required 0", seen3);
        end
        wb_flag   = 1'b1;
        wb_thread = 3'd3;
        tick();
        wb_flag   = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            if (issue_valid && issue_thread == 3'd3) found = 1'b1;
        end
        n_tests++;
        if (found !== 1'b1 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_release: reissued=%b ovf=%b unf=%b required 1 0 0", found, err_overflow, err_underflow);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(8'hFF);
        block_valid  = 1'b1;
        block_thread = 3'd1;
        tick();
        wb_flag      = 1'b1;
        wb_thread    = 3'd1;
        tick();
        wb_flag      = 1'b0;
        block_valid  = 1'b0;
        n_tests++;
        if (eligible_mask[1] !== 1'b1 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_hold: elig1=%b ovf=%b unf=%b required 1 0 0", eligible_mask[1], err_overflow, err_underflow);
        end
        // pending must still be 1, so exactly one more block saturates it
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
        n_tests++;
        if (eligible_mask[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_count: elig1=%b required 0", eligible_mask[1]);
        end
    endtask

    task automatic test_errors();
        do_reset(8'hFF);
        wb_flag   = 1'b1;
        wb_thread = 3'd6;
        tick();
        wb_flag   = 1'b0;
        n_tests++;
        if (err_underflow !== 1'b1 || err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_set: unf=%b ovf=%b required 1 0", err_underflow, err_overflow);
        end
        tick();
        tick();
        n_tests++;
        if (err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_sticky: unf=%b required 1", err_underflow);
        end
        block_valid  = 1'b1;
        block_thread = 3'd4;
        tick();
        tick();
        n_tests++;
        if (err_overflow !== 1'b0 || eligible_mask[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_pre: ovf=%b elig4=%b required 0 0", err_overflow, eligible_mask[4]);
        end
        tick();
        block_valid = 1'b0;
        n_tests++;
        if (err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: ovf=%b required 1", err_overflow);
        end
        // one write-back from a held count of 2 must re-enable thread 4
        wb_flag   = 1'b1;
        wb_thread = 3'd4;
        tick();
        wb_flag   = 1'b0;
        n_tests++;
        if (eligible_mask[4] !== 1'b1 || err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_hold: elig4=%b ovf=%b required 1 1", eligible_mask[4], err_overflow);
        end
    endtask

    task automatic test_stall();
        do_reset(8'hFF);
        for (int k = 0; k < 6; k++) tick();
        n_tests++;
        if (issue_thread !== 3'd5) begin
            n_fail++;
            $display("FAIL stall_pre: thread=%0d required 5", issue_thread);
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (issue_valid !== 1'b1 || issue_thread !== 3'd5) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b thread=%0d required 1 5", k, issue_valid, issue_thread);
            end
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (issue_valid !== 1'b1 || issue_thread !== 3'd6) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b thread=%0d required 1 6", issue_valid, issue_thread);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(8'hFF);
        block_valid  = 1'b1;
        block_thread = 3'd2;
        tick();
        tick();
        block_thread = 3'd7;
        tick();
        tick();
        block_valid  = 1'b0;
        wb_flag      = 1'b1;
        wb_thread    = 3'd0;
        tick();
        wb_flag      = 1'b0;
        n_tests++;
        if (eligible_mask !== 8'h7B || err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: elig=%h unf=%b required 7b 1", eligible_mask, err_underflow);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (issue_valid !== 1'b0 || issue_thread !== 3'd0 || eligible_mask !== 8'hFF || err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: valid=%b thread=%0d elig=%h unf=%b required 0 0 ff 0",
                     issue_valid, issue_thread, eligible_mask, err_underflow);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_bubbles();
        logic [31:0] exp_perf;
`ifdef THREAD_SCHED_PERF_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        do_reset(8'h00);
        for (int k = 0; k < 10; k++) tick();
        n_tests++;
        if (issue_valid !== 1'b0 || issue_thread !== 3'd0 || perf_bubble_count !== exp_perf) begin
            n_fail++;
            $display("FAIL bubbles: valid=%b thread=%0d perf=%0d required 0 0 %0d",
                     issue_valid, issue_thread, perf_bubble_count, exp_perf);
        end
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        n_tests++;
        if (perf_bubble_count !== exp_perf) begin
            n_fail++;
            $display("FAIL bubbles_stall: perf=%0d required %0d", perf_bubble_count, exp_perf);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        thread_enable = 8'h00;
        stall         = 1'b0;
        block_valid   = 1'b0;
        block_thread  = 3'd0;
        wb_flag       = 1'b0;
        wb_thread     = 3'd0;
        tick();
        test_reset();
        test_rotation();
        test_mask();
        test_saturation();
        test_simultaneous();
        test_errors();
        test_stall();
        test_reset_mid();
        test_bubbles();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
